// File: rtl/cache_fill_arbiter_pkg.sv
// Shared constants, state/target enums and address helper for the cache fill arbiter.
package cache_fill_arbiter_pkg;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int MEM_LATENCY       = 4;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int ADDR_W            = 16;
  localparam int DATA_W            = 16;
  localparam int WORD_IDX_W        = 3;
  localparam int BASE_W            = ADDR_W - BLOCK_OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_e;

  typedef enum logic {
    TGT_I,
    TGT_D
  } fill_tgt_e;

  // Word k of a block lives at {base, k, 0}: 16-bit words, byte addressed.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [BASE_W-1:0]     base,
                                                  input logic [WORD_IDX_W-1:0] k);
    return {base, k, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Cache-side and memory-side signal bundle of the fill arbiter.
interface cache_fill_arbiter_if;
  import cache_fill_arbiter_pkg::*;

  logic                  i_miss;
  logic [ADDR_W-1:0]     i_miss_addr;
  logic                  d_miss;
  logic [ADDR_W-1:0]     d_miss_addr;
  logic                  st_req;
  logic [ADDR_W-1:0]     st_addr;
  logic [DATA_W-1:0]     st_data;
  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     fill_data;
  logic [WORD_IDX_W-1:0] fill_word;
  logic                  fill_wr_i;
  logic                  fill_wr_d;
  logic                  tag_wr_i;
  logic                  tag_wr_d;
  logic                  i_busy;
  logic                  d_busy;
  logic                  st_ack;

  // master: caches plus main memory; slave: the arbiter
  modport master (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, st_req, st_addr, st_data,
           mem_rdata, mem_rvalid,
    input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
           fill_wr_i, fill_wr_d, tag_wr_i, tag_wr_d, i_busy, d_busy, st_ack
  );

  modport slave (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, st_req, st_addr, st_data,
           mem_rdata, mem_rvalid,
    output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
           fill_wr_i, fill_wr_d, tag_wr_i, tag_wr_d, i_busy, d_busy, st_ack
  );

endinterface

// File: rtl/cache_fill_arbiter_fill_word_counter.sv
// 3-bit word counter for a block fill: counts 0..7, then raises a sticky done flag
// and holds at 7 instead of wrapping.
module fill_word_counter
  import cache_fill_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [WORD_IDX_W-1:0] cnt,
  output logic                  done
);

  localparam logic [WORD_IDX_W-1:0] LAST = WORD_IDX_W'(WORDS_PER_BLOCK - 1);

  logic [WORD_IDX_W-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (en && !done_q) begin
      if (cnt_q == LAST) begin
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates write-through stores and I/D block fills onto one main-memory port,
// streaming returned words into the target cache's data array.
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  cache_fill_arbiter_if.slave bus
);

  fill_state_e           state_q, state_d;
  fill_tgt_e             tgt_q, tgt_d;
  logic [BASE_W-1:0]     base_q, base_d;

  logic                  cnt_clr;
  logic                  iss_en, rcv_en;
  logic [WORD_IDX_W-1:0] iss_cnt, rcv_cnt;
  logic                  iss_done, rcv_done;
  logic                  in_fill;

  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(WORDS_PER_BLOCK - 1);

  fill_word_counter u_issue_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (iss_en),
    .cnt  (iss_cnt),
    .done (iss_done)
  );

  fill_word_counter u_recv_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (rcv_en),
    .cnt  (rcv_cnt),
    .done (rcv_done)
  );

  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    base_d        = base_q;
    cnt_clr       = 1'b0;
    iss_en        = 1'b0;
    rcv_en        = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.fill_data = '0;
    bus.fill_word = '0;
    bus.fill_wr_i = 1'b0;
    bus.fill_wr_d = 1'b0;
    bus.tag_wr_i  = 1'b0;
    bus.tag_wr_d  = 1'b0;
    bus.st_ack    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (bus.st_req) begin
          bus.mem_en    = 1'b1;
          bus.mem_wr    = 1'b1;
          bus.mem_addr  = bus.st_addr;
          bus.mem_wdata = bus.st_data;
          bus.st_ack    = 1'b1;
        end else if (bus.d_miss) begin
          tgt_d   = TGT_D;
          base_d  = bus.d_miss_addr[ADDR_W-1:BLOCK_OFFSET_BITS];
          state_d = FILL;
        end else if (bus.i_miss) begin
          tgt_d   = TGT_I;
          base_d  = bus.i_miss_addr[ADDR_W-1:BLOCK_OFFSET_BITS];
          state_d = FILL;
        end
      end

      FILL: begin
        if (!iss_done) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = word_addr(base_q, iss_cnt);
          iss_en       = 1'b1;
        end
        // Responses come back in issue order, so the receive count is the word index.
        if (bus.mem_rvalid && !rcv_done) begin
          rcv_en        = 1'b1;
          bus.fill_data = bus.mem_rdata;
          bus.fill_word = rcv_cnt;
          bus.fill_wr_i = (tgt_q == TGT_I);
          bus.fill_wr_d = (tgt_q == TGT_D);
          if (rcv_cnt == LAST_WORD) begin
            bus.tag_wr_i = (tgt_q == TGT_I);
            bus.tag_wr_d = (tgt_q == TGT_D);
            state_d      = DONE;
          end
        end
      end

      DONE: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end

      default: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // A miss that is merely waiting behind another fill or a store is covered by its own
  // miss term; the target term keeps the cache stalled through DONE even after the miss drops.
  assign in_fill    = (state_q != IDLE);
  assign bus.i_busy = bus.i_miss || (in_fill && tgt_q == TGT_I);
  assign bus.d_busy = bus.d_miss || (in_fill && tgt_q == TGT_D) || (bus.st_req && !bus.st_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= TGT_I;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: doc/cache_fill_arbiter.md
CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning), listed one per line in REQ-002 to REQ-017.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_miss  in  1  I-cache miss detected; held until the fill completes.
REQ-005 i_miss_addr  in  16  byte address of the I-cache miss.
REQ-006 d_miss  in  1  D-cache read miss detected; held until the fill completes.
REQ-007 d_miss_addr  in  16  byte address of the D-cache miss.
REQ-008 st_req, st_addr, st_data  in  1/16/16  write-through store request (no write-allocate), with its address and data.
REQ-009 mem_en, mem_wr  out  1/1  main-memory request enable and write select.
REQ-010 mem_addr, mem_wdata  out  16/16  main-memory byte address and write data.
REQ-011 mem_rdata, mem_rvalid  in  16/1  main-memory read data and valid, returned a fixed MEM_LATENCY cycles after issue.
REQ-012 fill_data  out  16  word to write into the cache data array.
REQ-013 fill_word  out  3  word offset within the block for fill_data.
REQ-014 fill_wr_i, fill_wr_d  out  1/1  data-array write strobe for the I-cache / D-cache.
REQ-015 tag_wr_i, tag_wr_d  out  1/1  tag+valid write strobe, pulsed with the final word.
REQ-016 i_busy, d_busy  out  1/1  pipeline stall request per cache.
REQ-017 st_ack  out  1  store accepted this cycle.

Function
REQ-018 Block = 16 bytes = 8 words; block base = addr[15:4]; word k address = {addr[15:4], k[2:0], 1'b0}.
REQ-019 FSM states SHALL be IDLE, FILL, DONE.
REQ-020 IDLE priority SHALL be: st_req, then d_miss, then i_miss; one request accepted per cycle.
REQ-021 Store in IDLE: same cycle mem_en=1, mem_wr=1, mem_addr=st_addr, mem_wdata=st_data, st_ack=1; FSM stays IDLE.
REQ-022 Accepting a miss SHALL latch its block base and target cache (I or D), then go to FILL next cycle.
REQ-023 In FILL, one read SHALL be issued per cycle for words 0..7 in order (issue counter 0..7), mem_wr=0; no reads after word 7.
REQ-024 Each mem_rvalid in FILL SHALL drive fill_data=mem_rdata, fill_word=receive counter, and assert fill_wr of the target cache the same cycle (combinational).
REQ-025 On receive counter = 7 with mem_rvalid, the target tag_wr SHALL pulse the same cycle, and the FSM SHALL go to DONE.
REQ-026 DONE lasts exactly 1 cycle to allow cache re-lookup, then returns to IDLE.
REQ-027 Fill latency: miss accepted cycle T -> first fill_wr at T+1+MEM_LATENCY -> tag_wr at T+8+MEM_LATENCY -> IDLE at T+10+MEM_LATENCY.
REQ-028 i_busy SHALL be high while i_miss is high or the target is I in FILL/DONE; also high while a D fill or store blocks a pending i_miss. d_busy is defined analogously, and is also high while st_req waits.
REQ-029 A st_req arriving during FILL/DONE SHALL wait with st_ack=0 until IDLE; a store SHALL never interleave with a fill.
REQ-030 mem_rvalid outside FILL SHALL be ignored; no strobes.
REQ-031 A miss deasserting mid-fill SHALL be ignored; the fill always completes all 8 words.
REQ-032 Counters SHALL be 3-bit with no wrap beyond 7; the issue counter saturates at its done condition.

Reset
REQ-033 rst high at a clock edge SHALL force IDLE, clear counters and latches; all outputs 0 the next cycle, mid-fill included (partial block left without tag write).
REQ-034 Read responses still in flight after reset SHALL be discarded per REQ-030.

Structure
REQ-035 Shared package: WORDS_PER_BLOCK=8, MEM_LATENCY=4, BLOCK_OFFSET_BITS=4, state enum {IDLE, FILL, DONE}.
REQ-036 One sub-module, fill_word_counter (3-bit, enable, clear, done flag), SHALL be instantiated twice (issue and receive).

Verification
REQ-037 d_miss addr 0x1236 -> reads issued to 0x1230..0x123E; fill_wr_d for words 0..7 at cycles T+5..T+12; tag_wr_d at T+12; d_busy low at T+14.
REQ-038 i_miss and d_miss in the same cycle -> D fill first; I fill starts the cycle after the D DONE; i_busy stays high throughout.
REQ-039 st_req 0x0040/0xBEEF during an I fill -> st_ack=0 until IDLE, then one write cycle, mem_addr=0x0040, mem_wdata=0xBEEF.
REQ-040 st_req and i_miss simultaneous in IDLE -> store acked that cycle; fill issues 0x...0 starting the next cycle.
REQ-041 rst asserted after 3 received words -> all outputs 0, remaining mem_rvalid pulses produce no fill_wr/tag_wr.
REQ-042 mem_rvalid pulsed while IDLE -> no strobes, state unchanged.
